// File: rtl/gate_exerciser.sv
// gate_exerciser: initiator-side driver and checker for a two-input bitwise
// AND gate. Sweeps every {a,b} operand pair, holds each for SETTLE cycles,
// samples the gate response on the last cycle of the window and counts
// mismatches against a & b in a saturating counter.
//
// Optional build macro GATE_EXERCISER_FIRST_FAIL_EN adds fail_vld/fail_idx/
// fail_rsp, which capture the first mismatching vector of a sweep.
module gate_exerciser #(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_cnt,
  output logic [2*WIDTH-1:0]   vec_idx,
  output logic [WIDTH-1:0]     drv_a,
  output logic [WIDTH-1:0]     drv_b,
  input  logic [WIDTH-1:0]     rsp
`ifdef GATE_EXERCISER_FIRST_FAIL_EN
  ,
  output logic                 fail_vld,
  output logic [2*WIDTH-1:0]   fail_idx,
  output logic [WIDTH-1:0]     fail_rsp
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int IDX_W = 2 * WIDTH;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = '1;
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] drv_a_q;
  logic [WIDTH-1:0] drv_b_q;
  logic [CNT_W-1:0] cnt_q;

  logic             window_end;
  logic             mismatch;
  logic [ERR_W-1:0] err_d;
  logic [IDX_W-1:0] idx_d;

`ifdef GATE_EXERCISER_FIRST_FAIL_EN
  logic             fail_vld_q;
  logic [IDX_W-1:0] fail_idx_q;
  logic [WIDTH-1:0] fail_rsp_q;
`endif

  // Compare at the last cycle of each settle window; build next error count and index.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    window_end = 1'b0;
    mismatch   = 1'b0;
    err_d      = err_q;
    idx_d      = idx_q + IDX_ONE;
    if (state_q == S_DRIVE && cnt_q == CNT_LAST) begin
      window_end = 1'b1;
      mismatch   = (rsp != (drv_a_q & drv_b_q));
    end
    if (mismatch && err_q != ERR_MAX) begin
      err_d = err_q + ERR_ONE;
    end
  end

  // Sweep controller: state, operand drive, settle timing and result flags.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      idx_q   <= '0;
      drv_a_q <= '0;
      drv_b_q <= '0;
      cnt_q   <= '0;
`ifdef GATE_EXERCISER_FIRST_FAIL_EN
      fail_vld_q <= 1'b0;
      fail_idx_q <= '0;
      fail_rsp_q <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_DRIVE;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            idx_q   <= '0;
            drv_a_q <= '0;
            drv_b_q <= '0;
            cnt_q   <= '0;
`ifdef GATE_EXERCISER_FIRST_FAIL_EN
            fail_vld_q <= 1'b0;
            fail_idx_q <= '0;
            fail_rsp_q <= '0;
`endif
          end
        end
        S_DRIVE: begin
          err_q <= err_d;
`ifdef GATE_EXERCISER_FIRST_FAIL_EN
          if (mismatch && !fail_vld_q) begin
            fail_vld_q <= 1'b1;
            fail_idx_q <= idx_q;
            fail_rsp_q <= rsp;
          end
`endif
          if (window_end) begin
            cnt_q <= '0;
            if (idx_q == IDX_LAST) begin
              // Last vector: stop without wrapping the index; operands hold.
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
            end else begin
              idx_q   <= idx_d;
              drv_a_q <= idx_d[IDX_W-1:WIDTH];
              drv_b_q <= idx_d[WIDTH-1:0];
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_q;
  assign vec_idx = idx_q;
  assign drv_a   = drv_a_q;
  assign drv_b   = drv_b_q;

`ifdef GATE_EXERCISER_FIRST_FAIL_EN
  assign fail_vld = fail_vld_q;
  assign fail_idx = fail_idx_q;
  assign fail_rsp = fail_rsp_q;
`endif

endmodule
